// File: rtl/snoop_bus_arbiter_pkg.sv
// Shared bus types for the snoop bus arbiter: operation codes, snoop results,
// the broadcast message layout and the arbiter FSM state.
package pkg_bus;

   typedef enum logic [2:0] {
      OP_READ       = 3'd0,
      OP_WRITE      = 3'd1,
      OP_RWIM       = 3'd2,
      OP_INVALIDATE = 3'd3
   } bus_operation_e;

   typedef enum logic [1:0] {
      SNOOP_NOHIT = 2'd0,
      SNOOP_HIT   = 2'd1,
      SNOOP_HITM  = 2'd2
   } snoop_result_e;

   typedef struct packed {
      bus_operation_e operation;
      logic [31:0]    address;
      logic [3:0]     cache_id;
   } bus_msg_st;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } arb_state_e;

   // Wide enough for the largest legal snoop timeout (255).
   localparam int TIMEOUT_W = 8;

   function automatic logic op_needs_snoop(input bus_operation_e op);
      return (op == OP_READ) || (op == OP_WRITE) || (op == OP_RWIM);
   endfunction

   function automatic logic op_is_legal(input bus_operation_e op);
      return op_needs_snoop(op) || (op == OP_INVALIDATE);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first active request strictly after
// 'last', wrapping around, as a one-hot grant plus its index.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx
);

   logic             found;
   logic [IDX_W-1:0] cand;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = IDX_W'((int'(last) + i) % NUM_REQ);
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Round-robin snoop bus arbiter: grants one cache requester at a time,
// broadcasts its operation, collects a snoop response and returns it.
module snoop_bus_arbiter
   import pkg_bus::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int SNOOP_TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ*3-1:0]  req_op,
   input  logic [NUM_REQ*32-1:0] req_addr,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic                  bus_valid,
   output logic [38:0]           bus_msg,
   input  logic                  snoop_valid,
   input  logic [1:0]            snoop_result,
   output logic [NUM_REQ-1:0]    rsp_valid,
   output logic [1:0]            rsp_result,
   output logic                  rsp_timeout,
   output logic                  rsp_err,
   output logic                  busy
);

   localparam int IDX_W = $clog2(NUM_REQ);

   arb_state_e       state_q, state_d;
   bus_operation_e   op_q, op_d;
   logic [31:0]      addr_q, addr_d;
   logic [IDX_W-1:0] gid_q, gid_d;
   logic [IDX_W-1:0] last_q, last_d;
   logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
   snoop_result_e    res_q, res_d;
   logic             to_q, to_d;
   logic             err_q, err_d;

   logic [2:0]         op_arr   [NUM_REQ];
   logic [31:0]        addr_arr [NUM_REQ];
   logic [NUM_REQ-1:0] gnt;
   logic [IDX_W-1:0]   gnt_idx;
   bus_msg_st          msg;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         op_arr[i]   = req_op[3*i +: 3];
         addr_arr[i] = req_addr[32*i +: 32];
      end
   end

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
      .req     (req_valid),
      .last    (last_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      addr_d    = addr_q;
      gid_d     = gid_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      res_d     = res_q;
      to_d      = to_q;
      err_d     = err_q;
      req_ready = '0;
      case (state_q)
         ST_IDLE: begin
            if (|req_valid) begin
               req_ready = gnt;
               op_d      = bus_operation_e'(op_arr[gnt_idx]);
               addr_d    = addr_arr[gnt_idx];
               gid_d     = gnt_idx;
               last_d    = gnt_idx;
               res_d     = SNOOP_NOHIT;
               to_d      = 1'b0;
               err_d     = 1'b0;
               state_d   = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d = '0;
            if (op_needs_snoop(op_q)) begin
               state_d = ST_WAIT;
            end else begin
               // Invalidates complete without snooping; illegal codes are flagged.
               res_d   = SNOOP_NOHIT;
               err_d   = !op_is_legal(op_q);
               state_d = ST_RESP;
            end
         end
         ST_WAIT: begin
            if (snoop_valid) begin
               if (snoop_result == 2'b11) begin
                  res_d = SNOOP_NOHIT;
                  err_d = 1'b1;
               end else begin
                  res_d = snoop_result_e'(snoop_result);
               end
               state_d = ST_RESP;
            end else if (cnt_q == TIMEOUT_W'(SNOOP_TIMEOUT - 1)) begin
               res_d   = SNOOP_NOHIT;
               to_d    = 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         op_q    <= OP_READ;
         addr_q  <= '0;
         gid_q   <= '0;
         last_q  <= IDX_W'(NUM_REQ - 1);
         cnt_q   <= '0;
         res_q   <= SNOOP_NOHIT;
         to_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         gid_q   <= gid_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         to_q    <= to_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      msg.operation = op_q;
      msg.address   = addr_q;
      msg.cache_id  = 4'(gid_q);
   end

   assign busy        = (state_q != ST_IDLE);
   assign bus_msg     = busy ? msg : '0;
   assign bus_valid   = (state_q == ST_ISSUE) && op_is_legal(op_q);
   assign rsp_valid   = (state_q == ST_RESP) ? (NUM_REQ'(1) << gid_q) : '0;
   assign rsp_result  = (state_q == ST_RESP) ? res_q : SNOOP_NOHIT;
   assign rsp_timeout = (state_q == ST_RESP) && to_q;
   assign rsp_err     = (state_q == ST_RESP) && err_q;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter: cycle-exact checks in the main
// sequence plus a response scoreboard fed at grant time.
module tb_snoop_bus_arbiter;
   import pkg_bus::*;

   localparam int N = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N*3-1:0]  req_op;
   logic [N*32-1:0] req_addr;
   logic [N-1:0]    req_ready;
   logic            bus_valid;
   logic [38:0]     bus_msg;
   logic            snoop_valid;
   logic [1:0]      snoop_result;
   logic [N-1:0]    rsp_valid;
   logic [1:0]      rsp_result;
   logic            rsp_timeout;
   logic            rsp_err;
   logic            busy;

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_r;

   snoop_bus_arbiter #(.NUM_REQ(N), .SNOOP_TIMEOUT(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_op       (req_op),
      .req_addr     (req_addr),
      .req_ready    (req_ready),
      .bus_valid    (bus_valid),
      .bus_msg      (bus_msg),
      .snoop_valid  (snoop_valid),
      .snoop_result (snoop_result),
      .rsp_valid    (rsp_valid),
      .rsp_result   (rsp_result),
      .rsp_timeout  (rsp_timeout),
      .rsp_err      (rsp_err),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(negedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] addr);
      req_op[3*i +: 3]    = op;
      req_addr[32*i +: 32] = addr;
      req_valid[i]        = 1'b1;
   endtask

   function automatic logic [7:0] rsp_word(input int g, input logic [1:0] res,
                                           input logic to, input logic err);
      logic [3:0] oh;
      oh = 4'(1 << g);
      return {oh, res, to, err};
   endfunction

   function automatic logic [38:0] msg_word(input logic [2:0] op, input logic [31:0] addr,
                                            input int g);
      return {op, addr, 4'(g)};
   endfunction

   // Response scoreboard: every completion pulse must match the oldest grant.
   always @(negedge clk) begin
      #3;
      if (!rst && rsp_valid !== '0) begin
         if (exp_q.size() == 0) begin
            check("rsp_unexpected", 64'(rsp_valid), 64'd0);
         end else begin
            exp_r = exp_q.pop_front();
            check("rsp_scoreboard", 64'({rsp_valid, rsp_result, rsp_timeout, rsp_err}), 64'(exp_r));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b1;
      req_valid    = '0;
      req_op       = '0;
      req_addr     = '0;
      snoop_valid  = 1'b0;
      snoop_result = 2'b00;
      repeat (3) next_cycle();
      rst = 1'b0;
      next_cycle();

      // Reset state
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_bus_valid", 64'(bus_valid), 64'd0);
      check("rst_bus_msg", 64'(bus_msg), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_rsp_fields", 64'({rsp_result, rsp_timeout, rsp_err}), 64'd0);

      // Single READ from requester 0, snoop HIT at T+2
      set_req(0, OP_READ, 32'h0000_1040);
      #1 check("t1_ready", 64'(req_ready), 64'b0001);
      exp_q.push_back(rsp_word(0, SNOOP_HIT, 1'b0, 1'b0));
      next_cycle();
      req_valid = '0;
      #1 check("t1_bus_valid", 64'(bus_valid), 64'd1);
      check("t1_bus_msg", 64'(bus_msg), 64'(msg_word(OP_READ, 32'h0000_1040, 0)));
      check("t1_busy", 64'(busy), 64'd1);
      check("t1_ready_issue", 64'(req_ready), 64'd0);
      next_cycle();
      snoop_valid  = 1'b1;
      snoop_result = SNOOP_HIT;
      #1 check("t1_bus_valid_once", 64'(bus_valid), 64'd0);
      check("t1_bus_msg_hold", 64'(bus_msg), 64'(msg_word(OP_READ, 32'h0000_1040, 0)));
      check("t1_no_early_rsp", 64'(rsp_valid), 64'd0);
      next_cycle();
      snoop_valid = 1'b0;
      #1 check("t1_rsp_valid", 64'(rsp_valid), 64'b0001);
      check("t1_rsp_result", 64'(rsp_result), 64'(SNOOP_HIT));
      next_cycle();
      check("t1_idle_busy", 64'(busy), 64'd0);
      check("t1_idle_msg", 64'(bus_msg), 64'd0);
      check("t1_idle_result", 64'(rsp_result), 64'd0);

      // Fairness from a fresh reset: all four held high, INVALIDATE ops
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      next_cycle();
      for (int i = 0; i < N; i++) set_req(i, OP_INVALIDATE, 32'hA000_0000 + 32'(i * 16));
      for (int k = 0; k < 5; k++) begin
         #1 check("fair_grant", 64'(req_ready), 64'(1 << (k % N)));
         exp_q.push_back(rsp_word(k % N, SNOOP_NOHIT, 1'b0, 1'b0));
         next_cycle();
         #1 check("fair_bus_msg", 64'(bus_msg),
                  64'(msg_word(OP_INVALIDATE, 32'hA000_0000 + 32'((k % N) * 16), k % N)));
         next_cycle();
         #1 check("fair_rsp", 64'(rsp_valid), 64'(1 << (k % N)));
         next_cycle();
         if (k == 4) req_valid = '0;
      end
      #1 check("fair_idle_ready", 64'(req_ready), 64'd0);

      // Timeout: WRITE from requester 2, no snoop
      next_cycle();
      set_req(2, OP_WRITE, 32'h0000_2000);
      #1 check("to_ready", 64'(req_ready), 64'b0100);
      exp_q.push_back(rsp_word(2, SNOOP_NOHIT, 1'b1, 1'b0));
      next_cycle();
      req_valid = '0;
      #1 check("to_bus_valid", 64'(bus_valid), 64'd1);
      for (int w = 0; w < 16; w++) begin
         next_cycle();
         check("to_wait_no_rsp", 64'(rsp_valid), 64'd0);
      end
      next_cycle();
      check("to_rsp_valid", 64'(rsp_valid), 64'b0100);
      check("to_rsp_timeout", 64'(rsp_timeout), 64'd1);
      check("to_rsp_result", 64'(rsp_result), 64'(SNOOP_NOHIT));
      next_cycle();

      // Snoop HITM in the final WAIT cycle wins over timeout; snoop in ISSUE ignored
      set_req(1, OP_RWIM, 32'h0000_3000);
      #1 check("hitm_ready", 64'(req_ready), 64'b0010);
      exp_q.push_back(rsp_word(1, SNOOP_HITM, 1'b0, 1'b0));
      next_cycle();
      req_valid    = '0;
      snoop_valid  = 1'b1;
      snoop_result = SNOOP_HIT;
      #1 check("hitm_bus_valid", 64'(bus_valid), 64'd1);
      for (int w = 0; w < 16; w++) begin
         next_cycle();
         snoop_valid  = (w == 15);
         snoop_result = (w == 15) ? SNOOP_HITM : SNOOP_NOHIT;
      end
      next_cycle();
      snoop_valid = 1'b0;
      #1 check("hitm_rsp_valid", 64'(rsp_valid), 64'b0010);
      check("hitm_result", 64'(rsp_result), 64'(SNOOP_HITM));
      check("hitm_timeout", 64'(rsp_timeout), 64'd0);
      next_cycle();

      // INVALIDATE from requester 3 completes at T+2 without WAIT
      set_req(3, OP_INVALIDATE, 32'h0000_4000);
      #1 check("inv_ready", 64'(req_ready), 64'b1000);
      exp_q.push_back(rsp_word(3, SNOOP_NOHIT, 1'b0, 1'b0));
      next_cycle();
      req_valid = '0;
      #1 check("inv_bus_valid", 64'(bus_valid), 64'd1);
      next_cycle();
      check("inv_rsp_t2", 64'(rsp_valid), 64'b1000);
      next_cycle();
      check("inv_done", 64'(busy), 64'd0);

      // Illegal op 3'b111 from requester 0: no broadcast, error response
      set_req(0, 3'b111, 32'h0000_5000);
      #1 check("ill_ready", 64'(req_ready), 64'b0001);
      exp_q.push_back(rsp_word(0, SNOOP_NOHIT, 1'b0, 1'b1));
      next_cycle();
      req_valid = '0;
      #1 check("ill_no_bus_valid", 64'(bus_valid), 64'd0);
      check("ill_busy", 64'(busy), 64'd1);
      next_cycle();
      check("ill_rsp_valid", 64'(rsp_valid), 64'b0001);
      check("ill_rsp_err", 64'(rsp_err), 64'd1);
      next_cycle();

      // Illegal snoop code 2'b11 becomes NOHIT with error
      set_req(1, OP_READ, 32'h0000_6000);
      #1 check("bad_snoop_ready", 64'(req_ready), 64'b0010);
      exp_q.push_back(rsp_word(1, SNOOP_NOHIT, 1'b0, 1'b1));
      next_cycle();
      req_valid = '0;
      next_cycle();
      snoop_valid  = 1'b1;
      snoop_result = 2'b11;
      next_cycle();
      snoop_valid = 1'b0;
      #1 check("bad_snoop_err", 64'(rsp_err), 64'd1);
      check("bad_snoop_result", 64'(rsp_result), 64'(SNOOP_NOHIT));
      next_cycle();

      // Reset during WAIT aborts the operation; later snoop ignored
      set_req(2, OP_READ, 32'h0000_7000);
      #1 check("abort_ready", 64'(req_ready), 64'b0100);
      next_cycle();
      req_valid = '0;
      next_cycle();
      check("abort_in_wait", 64'(busy), 64'd1);
      rst = 1'b1;
      next_cycle();
      rst          = 1'b0;
      snoop_valid  = 1'b1;
      snoop_result = SNOOP_HIT;
      #1 check("abort_busy", 64'(busy), 64'd0);
      check("abort_no_rsp", 64'(rsp_valid), 64'd0);
      next_cycle();
      snoop_valid = 1'b0;
      check("abort_busy_after_snoop", 64'(busy), 64'd0);
      check("abort_no_rsp_after_snoop", 64'(rsp_valid), 64'd0);
      for (int i = 0; i < N; i++) set_req(i, OP_INVALIDATE, 32'h0000_8000);
      #1 check("abort_next_grant", 64'(req_ready), 64'b0001);
      exp_q.push_back(rsp_word(0, SNOOP_NOHIT, 1'b0, 1'b0));
      next_cycle();
      req_valid = '0;
      next_cycle();
      check("abort_next_rsp", 64'(rsp_valid), 64'b0001);
      repeat (3) next_cycle();
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
